// File: rtl/pwm_timebase_counter.sv
// pwm_timebase_counter: prescaled up/down/triangle PWM timebase with shadowed period and phase sync.
module pwm_timebase_counter #(
  parameter int WIDTH       = 16,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_en,
  input  logic [1:0]             i_mode,
  input  logic [PRESC_WIDTH-1:0] i_prescale,
  input  logic [WIDTH-1:0]       i_period,
  input  logic                   i_period_wr,
  input  logic                   i_shadow_en,
  input  logic                   i_sync_in,
  input  logic                   i_sync_in_en,
  input  logic [WIDTH-1:0]       i_phase,
  input  logic                   i_phase_dir,
  input  logic [1:0]             i_sync_sel,
  input  logic [WIDTH-1:0]       i_compare_b,
  input  logic                   i_sync_out_en,
  output logic [WIDTH-1:0]       o_count,
  output logic                   o_dir,
  output logic [WIDTH-1:0]       o_period_active,
  output logic                   o_zero,
  output logic                   o_prd,
  output logic                   o_sync
);
  logic [PRESC_WIDTH-1:0] p;
  logic [WIDTH-1:0] shadow, pe, nc;
  logic pending, nd, tick, load, xfer, sync_r, load_dir;
  assign tick = i_en & (p >= i_prescale);
  assign load = i_sync_in_en & i_sync_in & i_en & (i_mode != 2'b00);
  assign xfer = tick & ~load & pending & (o_count == '0);
  // the tick that transfers the shadow already counts against the new period
  assign pe = xfer ? shadow : o_period_active;
  assign load_dir = (i_mode == 2'b01) ? 1'b0 : (i_mode == 2'b10) ? 1'b1 : i_phase_dir;
  assign o_sync = sync_r & i_sync_out_en;
  always_comb begin
    nc = o_count;
    nd = o_dir;
    if (i_mode == 2'b01)
      nc = (o_count >= pe) ? '0 : o_count + 1'b1;
    else if (i_mode == 2'b10)
      nc = (o_count == '0) ? pe : o_count - 1'b1;
    else if (i_mode == 2'b11) begin
      if (pe == '0 && o_count == '0) begin
        nc = '0;
        nd = 1'b0;
      end else if (!o_dir) begin
        nd = o_count >= pe;
        nc = (o_count >= pe) ? o_count - 1'b1 : o_count + 1'b1;
      end else begin
        nd = o_count != '0;
        nc = (o_count == '0) ? o_count + 1'b1 : o_count - 1'b1;
      end
    end
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_count         <= '0;
      o_dir           <= 1'b0;
      o_period_active <= '0;
      shadow          <= '0;
      pending         <= 1'b0;
      p               <= '0;
      o_zero          <= 1'b0;
      o_prd           <= 1'b0;
      sync_r          <= 1'b0;
    end else begin
      o_zero <= 1'b0;
      o_prd  <= 1'b0;
      sync_r <= 1'b0;
      if (i_period_wr & ~i_shadow_en) begin
        o_period_active <= i_period;
        pending         <= 1'b0;
      end else begin
        if (xfer) begin
          o_period_active <= shadow;
          pending         <= 1'b0;
        end
        if (i_period_wr) begin
          shadow  <= i_period;
          pending <= 1'b1;
        end
      end
      if (load) begin
        o_count <= i_phase;
        o_dir   <= load_dir;
        p       <= '0;
      end else if (i_en) begin
        p <= tick ? '0 : p + 1'b1;
        if (tick) begin
          o_count <= nc;
          o_dir   <= nd;
          o_zero  <= nc == '0;
          o_prd   <= nc == pe;
          sync_r  <= (i_sync_sel == 2'b00) ? nc == '0 :
                     (i_sync_sel == 2'b01) ? nc == pe :
                     (nc == i_compare_b) & (nd == i_sync_sel[0]);
        end
      end
    end
  end
endmodule
